sdwc_deadlock_report_unit: RTL
==============================

# sdwc_deadlock_report_unit

Central deadlock controller for the per-process deadlock detect units of the StreamingDataWidthConverter HLS dataflow region. It collects every unit's `dl_detect_out` and qualifies one detection with a debounce filter. It then originates the report token at the detecting process, traces the token around the dependency cycle, and clears it. Finally it presents the deadlocked process ID and cycle membership on a valid/ready report port. Sits one level above the detect units; its `dl_detect_out`, `origin_vec` and `token_clear` feed their `dl_detect_in`, `origin` and `token_clear` inputs.

## Interface
- `PROC_NUM`, 4: number of processes/detect units (≥2).
- `DET_FILTER`, 4: consecutive cycles a detection must persist before acceptance (≥1).
- `TRACE_TIMEOUT`, 256: max TRACE cycles before forced report (≥2; used only with the timeout feature).
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state and outputs.
- `dl_detect_in_vec`  in  PROC_NUM  bit i = unit i's `dl_detect_out`.
- `proc_token_vec`  in  PROC_NUM  bit i = unit i currently holds the token (OR of its `token_in_vec`).
- `origin_vec`  out  PROC_NUM  one-hot origin strobe to the selected unit.
- `token_clear`  out  1  one-cycle token-clear pulse to all units.
- `dl_detect_out`  out  1  sticky "deadlock latched", broadcast to all units.
- `dl_proc_id`  out  $clog2(PROC_NUM)  index of the detecting process.
- `dl_cycle_vec`  out  PROC_NUM  processes visited by the token.
- `report_timeout`  out  1  report produced by timeout, not token return.
- `report_valid`  out  1  report available.
- `report_ready`  in  1  consumer accepts report.

## Operation
- FSM states: IDLE, FILTER, ORIGIN, TRACE, REPORT, DONE. All outputs are registered.
- IDLE: if any `dl_detect_in_vec` bit is set, latch the lowest set index k into `dl_proc_id` and set filter count to 1.
  - Go to ORIGIN if `DET_FILTER`=1; otherwise go to FILTER.
- FILTER:
  - If bit k is high: increment the count; on reaching `DET_FILTER`, go to ORIGIN.
  - If bit k is low: return to IDLE. No same-cycle reselection; other bits are ignored while in FILTER.
- ORIGIN (exactly 1 cycle):
  - `origin_vec` = 1<<k.
  - `dl_detect_out` goes to 1 and stays 1 until reset.
  - `dl_cycle_vec` = 1<<k; trace count = 0. Next state is TRACE.
- TRACE: each cycle, `dl_cycle_vec` |= `proc_token_vec` and the trace count increments.
  - Token returned: `proc_token_vec[k]`=1 with trace count ≥1. Go to REPORT with `report_timeout`=0.
- REPORT: `token_clear`=1 on the first REPORT cycle only. `report_valid`=1 until `report_ready` is sampled high, then go to DONE.
- DONE: `report_valid`=0. `dl_detect_out`, `dl_proc_id`, `dl_cycle_vec` and `report_timeout` hold. Exit only via reset.
- Report fields are stable while `report_valid`=1.

## Timing
- Reset values: `origin_vec`=0, `token_clear`=0, `dl_detect_out`=0, `dl_proc_id`=0, `dl_cycle_vec`=0, `report_timeout`=0, `report_valid`=0. State is IDLE.
- Detection first sampled at edge N: `origin_vec` is high in cycle N+`DET_FILTER`, and `dl_detect_out` rises in the same cycle.
- Token return sampled at edge T: `report_valid` and `token_clear` are high from cycle T+1.
- Handshake: transfer on a rising edge with `report_valid`&`report_ready`. `report_ready` held high gives a 1-cycle REPORT.
- Reset asserted mid-operation: outputs clear immediately (asynchronously). The first detection is sampled on the first edge after release.

## Configuration
- `DL_TRACE_TIMEOUT_EN` defined:
  - TRACE also exits to REPORT when trace count == `TRACE_TIMEOUT` with no token return, setting `report_timeout`=1. `token_clear` is still pulsed.
  - Token return and timeout in the same cycle: token return wins, `report_timeout`=0.
- `DL_TRACE_TIMEOUT_EN` undefined:
  - No timeout counter logic; TRACE waits indefinitely.
  - `report_timeout` is tied to 0. The trace count saturates and only qualifies "≥1".

## Test plan
- PROC_NUM=4, DET_FILTER=4: hold `dl_detect_in_vec`=4'b0100 from edge 10, with `proc_token_vec` sequence 0010, 1000, 0100 after ORIGIN, and `report_ready`=1.
  - Expect `origin_vec`=0100 in cycle 14 only.
  - Expect `dl_cycle_vec`=1110, `dl_proc_id`=2, `token_clear` and `report_valid` each a single pulse, then DONE.
- Hold `dl_detect_in_vec`=0010 for 3 cycles, then drop it -> no `origin_vec`, `dl_detect_out` stays 0, FSM back in IDLE.
- Same-cycle `dl_detect_in_vec`=1010 -> `dl_proc_id`=1 and `origin_vec`=0010.
- With `DL_TRACE_TIMEOUT_EN` and TRACE_TIMEOUT=8, `proc_token_vec`=0 throughout TRACE -> report after 8 TRACE cycles with `report_timeout`=1, `dl_cycle_vec`=1<<k.
- Hold `report_ready`=0 for 5 cycles in REPORT -> `report_valid` stays high with stable fields; `token_clear` is high only in the first cycle.
- Assert `reset` mid-TRACE -> all outputs go to 0 asynchronously; a new detection after release restarts from IDLE.

Source files
------------

// File: rtl/sdwc_deadlock_report_unit.sv
// Central deadlock controller: debounces one detection, drives the token trace, reports the cycle.
// Optional trace timeout enabled by defining DL_TRACE_TIMEOUT_EN.
module sdwc_deadlock_report_unit #(
  parameter int PROC_NUM      = 4,
  parameter int DET_FILTER    = 4,
  parameter int TRACE_TIMEOUT = 256
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [PROC_NUM-1:0]         dl_detect_in_vec,
  input  logic [PROC_NUM-1:0]         proc_token_vec,
  output logic [PROC_NUM-1:0]         origin_vec,
  output logic                        token_clear,
  output logic                        dl_detect_out,
  output logic [$clog2(PROC_NUM)-1:0] dl_proc_id,
  output logic [PROC_NUM-1:0]         dl_cycle_vec,
  output logic                        report_timeout,
  output logic                        report_valid,
  input  logic                        report_ready
);

  localparam int IW = $clog2(PROC_NUM);
  localparam int FW = $clog2(DET_FILTER + 1);

  if (PROC_NUM < 2 || DET_FILTER < 1 || TRACE_TIMEOUT < 2) begin : g_bad_cfg
    $error("sdwc_deadlock_report_unit: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILTER,
    S_ORIGIN,
    S_TRACE,
    S_REPORT,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [IW-1:0]       proc_id_q, proc_id_d;
  logic [FW-1:0]       filt_q, filt_d;
  logic [PROC_NUM-1:0] cyc_q, cyc_d;
  logic [PROC_NUM-1:0] origin_q, origin_d;
  logic                det_q, det_d;
  logic                clear_q, clear_d;
  logic                valid_q, valid_d;
  logic                trc_started;
  logic                tok_ret;
  logic                filt_done;

`ifdef DL_TRACE_TIMEOUT_EN
  localparam int TW = $clog2(TRACE_TIMEOUT + 1);
  logic [TW-1:0] trc_q, trc_d, trc_inc;
  logic          tmo_q, tmo_d;
  logic          tmo_hit;

  assign trc_started    = |trc_q;
  assign trc_inc        = trc_q + TW'(1);
  assign tmo_hit        = (trc_inc == TW'(TRACE_TIMEOUT));
  assign report_timeout = tmo_q;
`else
  // Without the timeout only "has TRACE run at least once" matters.
  logic trc_q, trc_d, trc_inc;

  assign trc_started    = trc_q;
  assign trc_inc        = 1'b1;
  assign report_timeout = 1'b0;
`endif

  function automatic logic [IW-1:0] lowest(input logic [PROC_NUM-1:0] v);
    lowest = '0;
    for (int i = PROC_NUM - 1; i >= 0; i--) begin
      if (v[i]) lowest = IW'(i);
    end
  endfunction

  assign tok_ret   = proc_token_vec[proc_id_q] && trc_started;
  assign filt_done = (filt_q + FW'(1)) == FW'(DET_FILTER);

  // State and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      proc_id_q <= '0;
      filt_q    <= '0;
      cyc_q     <= '0;
      origin_q  <= '0;
      det_q     <= 1'b0;
      clear_q   <= 1'b0;
      valid_q   <= 1'b0;
      trc_q     <= '0;
`ifdef DL_TRACE_TIMEOUT_EN
      tmo_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      proc_id_q <= proc_id_d;
      filt_q    <= filt_d;
      cyc_q     <= cyc_d;
      origin_q  <= origin_d;
      det_q     <= det_d;
      clear_q   <= clear_d;
      valid_q   <= valid_d;
      trc_q     <= trc_d;
`ifdef DL_TRACE_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (|dl_detect_in_vec)
          state_d = (DET_FILTER == 1) ? S_ORIGIN : S_FILTER;
      end
      S_FILTER: begin
        if (!dl_detect_in_vec[proc_id_q])
          state_d = S_IDLE;
        else if (filt_done)
          state_d = S_ORIGIN;
      end
      S_ORIGIN: state_d = S_TRACE;
      S_TRACE: begin
        if (tok_ret)
          state_d = S_REPORT;
`ifdef DL_TRACE_TIMEOUT_EN
        else if (tmo_hit)
          state_d = S_REPORT;
`endif
      end
      S_REPORT: begin
        if (valid_q && report_ready)
          state_d = S_DONE;
      end
      S_DONE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output values are computed from the next state so they appear registered.
  always_comb begin
    proc_id_d = proc_id_q;
    filt_d    = filt_q;
    cyc_d     = cyc_q;
    det_d     = det_q;
    trc_d     = trc_q;
    origin_d  = '0;
    clear_d   = 1'b0;
    valid_d   = 1'b0;
`ifdef DL_TRACE_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (|dl_detect_in_vec) begin
          proc_id_d = lowest(dl_detect_in_vec);
          filt_d    = FW'(1);
        end
      end
      S_FILTER: begin
        if (dl_detect_in_vec[proc_id_q])
          filt_d = filt_q + FW'(1);
      end
      S_TRACE: begin
        cyc_d = cyc_q | proc_token_vec;
        trc_d = trc_inc;
      end
      default: ;
    endcase
    if (state_d == S_ORIGIN) begin
      origin_d = PROC_NUM'(1) << proc_id_d;
      det_d    = 1'b1;
      cyc_d    = PROC_NUM'(1) << proc_id_d;
      trc_d    = '0;
`ifdef DL_TRACE_TIMEOUT_EN
      tmo_d    = 1'b0;
`endif
    end
    if (state_d == S_REPORT) begin
      valid_d = 1'b1;
      clear_d = (state_q != S_REPORT);
    end
`ifdef DL_TRACE_TIMEOUT_EN
    // Token return beats a coincident timeout.
    if (state_q == S_TRACE && state_d == S_REPORT)
      tmo_d = !tok_ret;
`endif
  end

  assign origin_vec    = origin_q;
  assign token_clear   = clear_q;
  assign dl_detect_out = det_q;
  assign dl_proc_id    = proc_id_q;
  assign dl_cycle_vec  = cyc_q;
  assign report_valid  = valid_q;

endmodule
